add8u_err_meter: RTL and testbench
==================================

ADD8U_ERR_METER -- requirements
Module: add8u_err_meter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with ports as follows.
- clk: input, 1 bit, rising-edge clock.
- rst: input, 1 bit, synchronous active-high reset.
- start: input, 1 bit, request for one exhaustive characterization run.
- a_o: output, 8 bits, registered operand A driven to the external 8-bit unsigned approximate adder.
- b_o: output, 8 bits, registered operand B driven to the external adder.
- approx_i: input, 9 bits, adder result for the current a_o/b_o; the external adder is combinational.
- busy: output, 1 bit, high while a run is in progress.
- done: output, 1 bit, one-cycle pulse when a run completes.
- err_cnt: output, 17 bits, number of vectors where approx_i differs from a_o+b_o (EP numerator).
- sum_abs_err: output, 25 bits, sum of |approx - exact| over all vectors (MAE numerator).
- max_abs_err: output, 9 bits, worst-case |approx - exact| (WCE).
- sum_sq_err: output, 34 bits, sum of (approx - exact)^2 (MSE numerator); present only under ADD8U_ERR_SQ_EN.

Function
REQ-002 The block SHALL use the states IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on start.
- RUN to DRAIN after vector 65535 is sampled.
- DRAIN to DONE after one cycle.
- DONE to IDLE after one cycle, or directly to RUN if start is high in DONE.
REQ-003 On accepting start, the block SHALL clear all accumulators, set the vector counter to 0 and assert busy from the next cycle.
REQ-004 a_o SHALL equal counter[15:8] and b_o SHALL equal counter[7:0]; the counter increments by 1 per RUN cycle and covers all 65536 pairs exactly once.
REQ-005 At each RUN edge, stage 1 SHALL register approx_i together with exact = a_o + b_o (9 bits, no overflow).
REQ-006 At the following edge, stage 2 SHALL accumulate the registered pair:
- abs error = |approx - exact|, computed in 10-bit signed arithmetic and stored in 9 bits;
- err_cnt increments when abs error is nonzero;
- max_abs_err keeps the running maximum.
REQ-007 busy SHALL be high for exactly 65537 consecutive cycles, covering RUN and DRAIN.
REQ-008 done SHALL pulse for exactly one cycle in DONE.
REQ-009 Result outputs SHALL remain stable from DONE until the next accepted start.
REQ-010 start SHALL be ignored while busy is high.
REQ-011 Accumulators SHALL saturate at all-ones; the specified widths are sufficient, so saturation is a defensive measure only.
REQ-012 a_o and b_o SHALL hold 0 outside RUN.

Reset
REQ-013 While rst is high at a clock edge, the block SHALL enter IDLE and clear the counter, a_o, b_o, both pipeline stages, busy, done and every result output to 0.
REQ-014 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-015 After an aborted run, the next start SHALL begin a full fresh run from vector 0.

Configuration
REQ-016 With ADD8U_ERR_SQ_EN defined, the block SHALL include the squarer and sum_sq_err port.
- The squarer is a 9x9 unsigned multiply, accumulated in stage 2.
REQ-017 Without ADD8U_ERR_SQ_EN, the sum_sq_err port, squarer and accumulator SHALL be absent.
- All other behaviour and timing are identical.

Structure
REQ-018 Package add8u_err_pkg SHALL hold:
- the state enum;
- N_VECTORS = 65536;
- width constants CNT_W=17, SAE_W=25, ERR_W=9 and SSE_W=34.
REQ-019 The stage-2 datapath SHALL be a sub-module, add8u_err_acc, with ports for clear, enable, abs error and results; the FSM and stimulus counter stay in the top module.

Verification
REQ-020 Exact loopback (approx_i = a_o+b_o):
- err_cnt=0, sum_abs_err=0, max_abs_err=0, sum_sq_err=0;
- busy high for 65537 cycles, then one done pulse.
REQ-021 approx_i = (a_o+b_o) with bit0 forced to 0:
- err_cnt=32768, sum_abs_err=32768, max_abs_err=1, sum_sq_err=32768.
REQ-022 approx_i tied to 0:
- err_cnt=65535, sum_abs_err=16711680, max_abs_err=510.
REQ-023 approx_i tied to 9'h1FF:
- max_abs_err=511, err_cnt=65536;
- check the 17-bit err_cnt full value with no saturation.
REQ-024 start pulsed at cycle 1000 of a run:
- the pulse is ignored and the run completes normally with the same results.
- start held high across DONE launches a back-to-back run with accumulators cleared.
REQ-025 rst asserted at cycle 30000 of a run:
- all outputs are 0 the next cycle and no done pulse occurs;
- a subsequent start reproduces the REQ-020 result.

Source files
------------

// File: rtl/add8u_err_pkg.sv
// Shared types and widths for the 8-bit unsigned approximate-adder error meter.
// The squared-error feature is selected by the ADD8U_ERR_SQ_EN macro.
package add8u_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_VECTORS = 65536;
    localparam int CNT_W     = 17;
    localparam int SAE_W     = 25;
    localparam int ERR_W     = 9;
    localparam int SSE_W     = 34;
    localparam int SQ_W      = 2 * ERR_W;

    // Magnitude of approx - exact; the 10-bit signed difference always fits 9 bits.
    function automatic logic [ERR_W-1:0] abs_diff(input logic [8:0] approx,
                                                  input logic [8:0] exact);
        logic signed [9:0] diff;
        logic signed [9:0] neg;
        diff = signed'({1'b0, approx}) - signed'({1'b0, exact});
        neg  = -diff;
        if (diff < 10'sd0) begin
            return neg[ERR_W-1:0];
        end else begin
            return diff[ERR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/add8u_err_meter_acc.sv
// Stage-2 error accumulators (module add8u_err_acc) with saturating sums.
// The squared-error accumulator exists only when ADD8U_ERR_SQ_EN is defined.
module add8u_err_acc
    import add8u_err_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [ERR_W-1:0] abs_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SAE_W-1:0] sum_abs_err,
    output logic [ERR_W-1:0] max_abs_err
`ifdef ADD8U_ERR_SQ_EN
    ,
    output logic [SSE_W-1:0] sum_sq_err
`endif
);

    logic [CNT_W:0] cnt_sum;
    logic [SAE_W:0] sae_sum;
    logic           is_err;

    assign is_err  = (abs_err != {ERR_W{1'b0}});
    assign cnt_sum = {1'b0, err_cnt} + {{CNT_W{1'b0}}, is_err};
    assign sae_sum = {1'b0, sum_abs_err} + {{(SAE_W + 1 - ERR_W){1'b0}}, abs_err};

    // Error count, absolute-error sum and running maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt     <= {CNT_W{1'b0}};
            sum_abs_err <= {SAE_W{1'b0}};
            max_abs_err <= {ERR_W{1'b0}};
        end else if (clear) begin
            err_cnt     <= {CNT_W{1'b0}};
            sum_abs_err <= {SAE_W{1'b0}};
            max_abs_err <= {ERR_W{1'b0}};
        end else if (en) begin
            err_cnt     <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            sum_abs_err <= sae_sum[SAE_W] ? {SAE_W{1'b1}} : sae_sum[SAE_W-1:0];
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end else begin
                max_abs_err <= max_abs_err;
            end
        end else begin
            err_cnt     <= err_cnt;
            sum_abs_err <= sum_abs_err;
            max_abs_err <= max_abs_err;
        end
    end

`ifdef ADD8U_ERR_SQ_EN
    logic [SQ_W-1:0]  sq;
    logic [SSE_W:0]   sse_sum;

    assign sq      = {{ERR_W{1'b0}}, abs_err} * {{ERR_W{1'b0}}, abs_err};
    assign sse_sum = {1'b0, sum_sq_err} + {{(SSE_W + 1 - SQ_W){1'b0}}, sq};

    // Squared-error sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_sq_err <= {SSE_W{1'b0}};
        end else if (clear) begin
            sum_sq_err <= {SSE_W{1'b0}};
        end else if (en) begin
            sum_sq_err <= sse_sum[SSE_W] ? {SSE_W{1'b1}} : sse_sum[SSE_W-1:0];
        end else begin
            sum_sq_err <= sum_sq_err;
        end
    end
`endif

endmodule

// File: rtl/add8u_err_meter.sv
// Exhaustive error characterisation of an external 8-bit unsigned approximate adder.
// Define ADD8U_ERR_SQ_EN to add the squared-error accumulator and sum_sq_err port.
module add8u_err_meter
    import add8u_err_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [7:0]       a_o,
    output logic [7:0]       b_o,
    input  logic [8:0]       approx_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SAE_W-1:0] sum_abs_err,
    output logic [ERR_W-1:0] max_abs_err
`ifdef ADD8U_ERR_SQ_EN
    ,
    output logic [SSE_W-1:0] sum_sq_err
`endif
);

    state_t           state;
    logic [15:0]      counter;
    logic             start_ok;
    logic [8:0]       exact;
    logic             s1_valid;
    logic [8:0]       s1_approx;
    logic [8:0]       s1_exact;
    logic [ERR_W-1:0] abs_err;

    // The counter is the operand register pair; it rests at 0 outside RUN.
    assign a_o      = counter[15:8];
    assign b_o      = counter[7:0];
    assign exact    = {1'b0, a_o} + {1'b0, b_o};
    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign abs_err  = abs_diff(s1_approx, s1_exact);

    // Run sequencing, vector counter and the busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    counter <= 16'd0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    done <= 1'b0;
                    busy <= 1'b1;
                    if (counter == 16'hFFFF) begin
                        state   <= DRAIN;
                        counter <= 16'd0;
                    end else begin
                        state   <= RUN;
                        counter <= counter + 16'd1;
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    counter <= 16'd0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                DONE: begin
                    done    <= 1'b0;
                    counter <= 16'd0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= 16'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the adder result alongside the exact sum of the same operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_approx <= 9'd0;
            s1_exact  <= 9'd0;
        end else if (state == RUN) begin
            s1_valid  <= 1'b1;
            s1_approx <= approx_i;
            s1_exact  <= exact;
        end else begin
            s1_valid  <= 1'b0;
            s1_approx <= 9'd0;
            s1_exact  <= 9'd0;
        end
    end

    add8u_err_acc u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .en          (s1_valid),
        .abs_err     (abs_err),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err)
`ifdef ADD8U_ERR_SQ_EN
        ,
        .sum_sq_err  (sum_sq_err)
`endif
    );

endmodule

// File: tb/tb_add8u_err_meter.sv
// Self-checking bench for add8u_err_meter: table-driven full runs plus reset/abort sequences.
module tb_add8u_err_meter;
    import add8u_err_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a_o;
    logic [7:0]  b_o;
    logic [8:0]  approx_i;
    logic        busy;
    logic        done;
    logic [16:0] err_cnt;
    logic [24:0] sum_abs_err;
    logic [8:0]  max_abs_err;
`ifdef ADD8U_ERR_SQ_EN
    logic [33:0] sum_sq_err;
`endif

    add8u_err_meter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_o         (a_o),
        .b_o         (b_o),
        .approx_i    (approx_i),
        .busy        (busy),
        .done        (done),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err)
`ifdef ADD8U_ERR_SQ_EN
        ,
        .sum_sq_err  (sum_sq_err)
`endif
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     mode   = 0;
    int     delta[256];
    longint exp_err, exp_sae, exp_max, exp_sse;

    typedef struct {
        int     mode;
        bit     chain;
        bit     use_model;
        longint err;
        longint sae;
        longint mx;
    } vec_t;
    vec_t tbl[4];

    // Behaviour of the simulated external adder: 0 exact, 1 bit0 cleared, 2 zero, 3 all ones, 4 random offset.
    function automatic logic [8:0] approx_of(input int m, input logic [7:0] a, input logic [7:0] b);
        int s;
        int r;
        s = int'(a) + int'(b);
        case (m)
            0: r = s;
            1: r = s - (s % 2);
            2: r = 0;
            3: r = 511;
            4: r = (s + delta[int'(a ^ b)] + 512) % 512;
            default: r = s;
        endcase
        return 9'(r);
    endfunction

    always_comb approx_i = approx_of(mode, a_o, b_o);

    // Reference: sweep all operand pairs with plain integer arithmetic.
    task automatic model(input int m, output longint e, output longint s, output longint mx, output longint q);
        longint d;
        e = 0; s = 0; mx = 0; q = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                d = longint'(approx_of(m, 8'(a), 8'(b))) - longint'(a + b);
                if (d < 0) d = -d;
                if (d != 0) e++;
                s += d;
                q += d * d;
                if (d > mx) mx = d;
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, ".err_cnt"}, longint'(err_cnt), exp_err);
        check({tag, ".sum_abs_err"}, longint'(sum_abs_err), exp_sae);
        check({tag, ".max_abs_err"}, longint'(max_abs_err), exp_max);
`ifdef ADD8U_ERR_SQ_EN
        check({tag, ".sum_sq_err"}, longint'(sum_sq_err), exp_sse);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, longint'(busy), 0);
        check({tag, ".done"}, longint'(done), 0);
        check({tag, ".ab"}, longint'({a_o, b_o}), 0);
        check({tag, ".err_cnt"}, longint'(err_cnt), 0);
        check({tag, ".sum_abs_err"}, longint'(sum_abs_err), 0);
        check({tag, ".max_abs_err"}, longint'(max_abs_err), 0);
`ifdef ADD8U_ERR_SQ_EN
        check({tag, ".sum_sq_err"}, longint'(sum_sq_err), 0);
`endif
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follows one run from its first RUN cycle through DONE.
    task automatic track_run(input string tag, input bit mid_pulse, input bit chain);
        int cnt = 0;
        int bad = 0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 70000) begin
            if ({a_o, b_o} !== 16'(cnt)) bad++;
            if (done !== 1'b0) bad++;
            cnt++;
            start = (mid_pulse && cnt == 1000) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".busy_cycles"}, longint'(cnt), 65537);
        check({tag, ".sequence"}, longint'(bad), 0);
        check({tag, ".done_pulse"}, longint'(done), 1);
        check({tag, ".ab_done"}, longint'({a_o, b_o}), 0);
        check_results(tag);
        if (chain) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end else begin
            @(negedge clk);
            check({tag, ".done_one_cycle"}, longint'(done), 0);
            check({tag, ".busy_after"}, longint'(busy), 0);
            check_results({tag, ".stable"});
        end
    endtask

    initial begin
        longint e, s, mx, q;
        bit chained;
        int bad;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) delta[i] = int'($urandom_range(0, 6)) - 3;

        tbl[0] = '{mode: 2, chain: 1'b1, use_model: 1'b0, err: 65535, sae: 16711680, mx: 510};
        tbl[1] = '{mode: 3, chain: 1'b0, use_model: 1'b0, err: 65536, sae: 16777216, mx: 511};
        tbl[2] = '{mode: 1, chain: 1'b0, use_model: 1'b0, err: 32768, sae: 32768,    mx: 1};
        tbl[3] = '{mode: 4, chain: 1'b0, use_model: 1'b1, err: 0,     sae: 0,        mx: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        chained = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model(tbl[i].mode, e, s, mx, q);
            exp_sse = q;
            if (tbl[i].use_model) begin
                exp_err = e; exp_sae = s; exp_max = mx;
            end else begin
                exp_err = tbl[i].err; exp_sae = tbl[i].sae; exp_max = tbl[i].mx;
            end
            mode = tbl[i].mode;
            if (!chained) start_pulse();
            track_run($sformatf("run%0d", i), 1'b0, tbl[i].chain);
            chained = tbl[i].chain;
        end

        // Abort a run part-way through with reset.
        mode = 2;
        start_pulse();
        repeat (30000) @(negedge clk);
        check("abort.partial_errors", longint'(err_cnt > 17'd0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("abort.no_done", longint'(bad), 0);

        // Fresh exact run after the abort, with a start pulse that must be ignored mid-run.
        mode = 0;
        exp_err = 0; exp_sae = 0; exp_max = 0; exp_sse = 0;
        start_pulse();
        track_run("post_abort", 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
